instr_executor: RTL and testbench

//  Downstream execute stage of instr_register. On a start command it walks a batch of register

---
 rtl/instr_register_pkg.sv | 46 ++++
 rtl/instr_divider.sv | 76 +++++++
 rtl/instr_executor.sv | 197 +++++++++++++++++++
 tb/tb_instr_executor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instr_register / instr_executor pair: instruction encoding,
// result type, executor FSM states and small sign helpers.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DIV_WAIT,
        OUT,
        DONE
    } exec_state_t;

    localparam int DIV_CYCLES_C = 32;

    function automatic result_t sext32(input operand_t v);
        return {{32{v[31]}}, v};
    endfunction

    // Unsigned magnitude; the most negative operand maps to 32'h8000_0000.
    function automatic logic [31:0] magnitude(input operand_t v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

endpackage

// File: rtl/instr_divider.sv
// Signed 32-bit iterative restoring divider. div_done pulses DIV_CYCLES+1 cycles after
// div_start; quotient truncates toward zero, remainder takes the dividend's sign.
module instr_divider
    import instr_register_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_C
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     div_start,
    input  operand_t dividend,
    input  operand_t divisor,
    output operand_t quotient,
    output operand_t remainder,
    output logic     div_done
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [31:0]      acc_q;
    logic [31:0]      quo_q;
    logic [31:0]      dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             run_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    logic [32:0]      shifted;
    logic [31:0]      sub;
    logic             fits;

    // The partial remainder is always below the divisor, so the difference fits in 32 bits.
    always_comb begin
        shifted = {acc_q, quo_q[31]};
        fits    = (shifted >= {1'b0, dvs_q});
        sub     = shifted[31:0] - dvs_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (div_start) begin
                acc_q     <= '0;
                quo_q     <= magnitude(dividend);
                dvs_q     <= magnitude(divisor);
                neg_quo_q <= dividend[31] ^ divisor[31];
                neg_rem_q <= dividend[31];
                cnt_q     <= '0;
                run_q     <= 1'b1;
            end else if (run_q) begin
                acc_q <= fits ? sub : shifted[31:0];
                quo_q <= {quo_q[30:0], fits};
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient  = neg_quo_q ? operand_t'(-quo_q) : operand_t'(quo_q);
    assign remainder = neg_rem_q ? operand_t'(-acc_q) : operand_t'(acc_q);
    assign div_done  = done_q;

endmodule

// File: rtl/instr_executor.sv
// Execute stage behind instr_register: walks a batch of locations, evaluates each opcode and
// streams results out on valid/ready. Optional EXEC_STATS_EN adds handshake/error counters.
module instr_executor
    import instr_register_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DIV_CYCLES = DIV_CYCLES_C
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  address_t     base_ptr,
    input  logic [5:0]   count,
    output logic         busy,
    output logic         done,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      res_data,
    output opcode_t      res_opc,
    output address_t     res_addr,
    output logic         res_err
`ifdef EXEC_STATS_EN
    ,
    output logic [15:0]  stat_exec_cnt,
    output logic [15:0]  stat_err_cnt
`endif
);

    exec_state_t  state_q;
    address_t     ptr_q;
    address_t     rd_ptr_q;
    logic [5:0]   rem_q;
    instruction_t instr_q;
    logic         busy_q;
    logic         done_q;
    logic         res_valid_q;
    result_t      res_data_q;
    opcode_t      res_opc_q;
    address_t     res_addr_q;
    logic         res_err_q;

    result_t      alu_res;
    address_t     ptr_inc;
    logic         is_div;
    logic         div_by_zero;
    logic         div_start;
    logic         div_done;
    operand_t     div_quotient;
    operand_t     div_remainder;

    always_comb begin
        alu_res = '0;
        case (instr_q.opc)
            PASSA:   alu_res = sext32(instr_q.op_a);
            PASSB:   alu_res = sext32(instr_q.op_b);
            ADD:     alu_res = sext32(instr_q.op_a) + sext32(instr_q.op_b);
            SUB:     alu_res = sext32(instr_q.op_a) - sext32(instr_q.op_b);
            MULT:    alu_res = sext32(instr_q.op_a) * sext32(instr_q.op_b);
            default: alu_res = '0;
        endcase
    end

    assign is_div      = (instr_q.opc == DIV) || (instr_q.opc == MOD);
    assign div_by_zero = (instr_q.op_b == '0);
    // Issued combinationally from EXEC so the divider loads on the same edge that enters DIV_WAIT.
    assign div_start   = (state_q == EXEC) && is_div && !div_by_zero;
    assign ptr_inc     = (ptr_q == address_t'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    instr_divider #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (instr_q.op_a),
        .divisor   (instr_q.op_b),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .div_done  (div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            instr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_opc_q   <= ZERO;
            res_addr_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q  <= base_ptr;
                        rem_q  <= count;
                        busy_q <= 1'b1;
                        if (count == '0) begin
                            state_q <= DONE;
                        end else begin
                            rd_ptr_q <= base_ptr;
                            state_q  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    instr_q <= instruction_word;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_opc_q  <= instr_q.opc;
                    res_addr_q <= ptr_q;
                    res_err_q  <= 1'b0;
                    if (is_div && div_by_zero) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (is_div) begin
                        state_q <= DIV_WAIT;
                    end else begin
                        res_data_q  <= alu_res;
                        res_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        res_data_q  <= (instr_q.opc == DIV) ? sext32(div_quotient)
                                                             : sext32(div_remainder);
                        res_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        ptr_q       <= ptr_inc;
                        rem_q       <= rem_q - 6'd1;
                        if (rem_q > 6'd1) begin
                            rd_ptr_q <= ptr_inc;
                            state_q  <= FETCH;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign read_pointer = rd_ptr_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_opc      = res_opc_q;
    assign res_addr     = res_addr_q;
    assign res_err      = res_err_q;

`ifdef EXEC_STATS_EN
    logic [15:0] stat_exec_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_exec_q <= '0;
            stat_err_q  <= '0;
        end else if (res_valid_q && res_ready) begin
            if (stat_exec_q != 16'hFFFF) begin
                stat_exec_q <= stat_exec_q + 16'd1;
            end
            if (res_err_q && (stat_err_q != 16'hFFFF)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign stat_exec_cnt = stat_exec_q;
    assign stat_err_cnt  = stat_err_q;
`endif

endmodule

// File: tb/tb_instr_executor.sv
// Directed bench for instr_executor: hand-computed results, latencies, pointer wrap,
// back-pressure, mid-divide reset and empty batch.
module tb_instr_executor;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    address_t     base_ptr;
    logic [5:0]   count;
    logic         busy;
    logic         done;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    result_t      res_data;
    opcode_t      res_opc;
    address_t     res_addr;
    logic         res_err;
`ifdef EXEC_STATS_EN
    logic [15:0]  stat_exec_cnt;
    logic [15:0]  stat_err_cnt;
`endif

    instruction_t regs [32];
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    assign instruction_word = regs[read_pointer];

    instr_executor dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_ptr         (base_ptr),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_opc          (res_opc),
        .res_addr         (res_addr),
        .res_err          (res_err)
`ifdef EXEC_STATS_EN
        ,
        .stat_exec_cnt    (stat_exec_cnt),
        .stat_err_cnt     (stat_err_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t w;
        w.opc  = o;
        w.op_a = a;
        w.op_b = b;
        return w;
    endfunction

    // Returns at the sample point just after the accept edge (cycle 1 of the batch).
    task automatic start_batch(input address_t base, input logic [5:0] cnt);
        @(negedge clk);
        start    = 1'b1;
        base_ptr = base;
        count    = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!res_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic take_result(input string tag, input longint exp_data, input int exp_addr,
                               input logic exp_err, input opcode_t exp_opc);
        int k;
        wait_valid(k);
        check_eq({tag, "_valid"}, 64'(res_valid), 64'd1);
        check_eq({tag, "_data"}, res_data, exp_data);
        check_eq({tag, "_addr"}, 64'(res_addr), 64'(exp_addr));
        check_eq({tag, "_err"}, 64'(res_err), 64'(exp_err));
        check_eq({tag, "_opc"}, 64'(res_opc), 64'(exp_opc));
        $display("result %s: addr=%0d opc=%s data=%0d err=%0b", tag, res_addr, res_opc.name(),
                 res_data, res_err);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    // Called at the sample just after the final handshake; expects exactly one done pulse.
    task automatic expect_done_pulse(input string tag);
        int n = 0;
        repeat (4) begin
            if (done) n++;
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_done_pulses"}, 64'(n), 64'd1);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        int nv;
        int nd;
        for (int i = 0; i < 32; i++) regs[i] = mk(ZERO, 0, 0);
        reset     = 1'b1;
        start     = 1'b0;
        base_ptr  = '0;
        count     = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_rdptr", 64'(read_pointer), 64'd0);
        check_eq("rst_valid", 64'(res_valid), 64'd0);
        check_eq("rst_data", res_data, 64'd0);
        check_eq("rst_opc", 64'(res_opc), 64'(ZERO));
        check_eq("rst_addr", 64'(res_addr), 64'd0);
        check_eq("rst_err", 64'(res_err), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: ADD / SUB / MULT
        regs[0] = mk(ADD, 5, 3);
        regs[1] = mk(SUB, -7, 2);
        regs[2] = mk(MULT, -15, 15);
        start_batch(5'd0, 6'd3);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_valid(k);
        check_eq("t1_latency", 64'(k), 64'd3);
        take_result("t1_add", 8, 0, 1'b0, ADD);
        take_result("t1_sub", -9, 1, 1'b0, SUB);
        take_result("t1_mult", -225, 2, 1'b0, MULT);
        expect_done_pulse("t1");

        // Test 3: divide by zero bypasses the divider
        regs[20] = mk(DIV, 7, 0);
        start_batch(5'd20, 6'd1);
        wait_valid(k);
        check_eq("t3_latency", 64'(k), 64'd3);
        take_result("t3_div0", 0, 20, 1'b1, DIV);
        expect_done_pulse("t3");
`ifdef EXEC_STATS_EN
        check_eq("stat_exec", 64'(stat_exec_cnt), 64'd4);
        check_eq("stat_err", 64'(stat_err_cnt), 64'd1);
`endif

        // Test 2: DIV / MOD signs
        regs[4] = mk(DIV, -15, 4);
        regs[5] = mk(MOD, -15, 4);
        regs[6] = mk(DIV, 7, -3);
        regs[7] = mk(MOD, 7, -3);
        start_batch(5'd4, 6'd4);
        wait_valid(k);
        check_eq("t2_latency", 64'(k), 64'd36);
        take_result("t2_div", -3, 4, 1'b0, DIV);
        take_result("t2_mod", -3, 5, 1'b0, MOD);
        take_result("t2_div_negb", -2, 6, 1'b0, DIV);
        take_result("t2_mod_negb", 1, 7, 1'b0, MOD);
        expect_done_pulse("t2");

        // Test 4: pointer wrap 30,31,0,1
        regs[30] = mk(PASSA, 100, 0);
        regs[31] = mk(PASSA, 101, 0);
        regs[0]  = mk(PASSA, 102, 0);
        regs[1]  = mk(PASSA, -103, 0);
        start_batch(5'd30, 6'd4);
        check_eq("t4_rdptr0", 64'(read_pointer), 64'd30);
        for (int i = 0; i < 4; i++) begin
            take_result($sformatf("t4_r%0d", i), (i == 3) ? -103 : 100 + i, (30 + i) % 32,
                        1'b0, PASSA);
            if (i < 3) check_eq($sformatf("t4_rdptr%0d", i + 1), 64'(read_pointer),
                                64'((31 + i) % 32));
        end
        expect_done_pulse("t4");

        // Test 5a: back-pressure holds outputs stable
        regs[10] = mk(PASSB, 0, -42);
        regs[11] = mk(ADD, 1, 1);
        start_batch(5'd10, 6'd2);
        wait_valid(k);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t5_hold_valid%0d", i), 64'(res_valid), 64'd1);
            check_eq($sformatf("t5_hold_data%0d", i), res_data, -64'sd42);
            @(posedge clk);
            #1;
        end
        check_eq("t5_hold_opc", 64'(res_opc), 64'(PASSB));
        check_eq("t5_hold_rdptr", 64'(read_pointer), 64'd10);
        take_result("t5_passb", -42, 10, 1'b0, PASSB);
        take_result("t5_add", 2, 11, 1'b0, ADD);
        expect_done_pulse("t5");

        // Test 5b: reset while dividing
        regs[12] = mk(DIV, 100, 7);
        start_batch(5'd12, 6'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("t5_rst_busy", 64'(busy), 64'd0);
        check_eq("t5_rst_valid", 64'(res_valid), 64'd0);
        nv = 0;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid) nv++;
            if (done) nd++;
        end
        check_eq("t5_rst_no_valid", 64'(nv), 64'd0);
        check_eq("t5_rst_no_done", 64'(nd), 64'd0);

        // Test 6: empty batch
        start_batch(5'd3, 6'd0);
        check_eq("t6_done_c1", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check_eq("t6_done_c2", 64'(done), 64'd1);
        nv = 0;
        repeat (3) begin
            if (res_valid) nv++;
            @(posedge clk);
            #1;
        end
        check_eq("t6_no_valid", 64'(nv), 64'd0);
        check_eq("t6_busy_after", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
